// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator.
//
// The envelope is a Q2.14 word (0x0000..FULL) that is updated only on
// sample_tick cycles. Gate edges change state on any clk edge. When a gate
// edge and a tick arrive together, the edge is applied first and the tick's
// arithmetic then runs in the new state.
//
// Ports:
//   clk           system clock
//   reset         asynchronous reset, active low
//   sample_tick   one-clk audio-rate strobe; enables level arithmetic
//   gate          note-on level (1 = key held)
//   attack_step   increment per tick in ATTACK
//   decay_step    decrement per tick in DECAY
//   sustain_level sustain target, clamped to FULL
//   release_step  decrement per tick in RELEASE
//   envelope      registered level, always within 0..FULL
//   state         0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
//   active        high whenever state != IDLE
//   done          one-clk pulse when RELEASE reaches 0
module adsr_envelope #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned FULL = 1 << FRAC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_tick,
  input  logic         gate,
  input  logic [W-1:0] attack_step,
  input  logic [W-1:0] decay_step,
  input  logic [W-1:0] sustain_level,
  input  logic [W-1:0] release_step,
  output logic [W-1:0] envelope,
  output logic [2:0]   state,
  output logic         active,
  output logic         done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [W-1:0] FULL_W = W'(FULL);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] env_q, env_d;
  logic         done_q, done_d;
  logic         gate_q;
  // Rises are ignored until gate has been seen low once after reset, so a
  // key held across reset release does not retrigger the voice.
  logic         armed_q;

  logic         rise, fall;
  logic [W-1:0] sus_tgt;
  logic [W:0]   attack_sum;
  logic [W:0]   decay_thr;

  assign rise = gate & ~gate_q & armed_q;
  assign fall = ~gate & gate_q;

  assign sus_tgt    = (sustain_level > FULL_W) ? FULL_W : sustain_level;
  assign attack_sum = {1'b0, env_q} + {1'b0, attack_step};
  assign decay_thr  = {1'b0, sus_tgt} + {1'b0, decay_step};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    done_d  = 1'b0;

    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end

    if (sample_tick) begin
      case (state_d)
        ATTACK: begin
          if (attack_step == '0 || attack_sum >= {1'b0, FULL_W}) begin
            env_d   = FULL_W;
            state_d = DECAY;
          end else begin
            env_d = attack_sum[W-1:0];
          end
        end
        DECAY: begin
          if (decay_step == '0 || {1'b0, env_q} <= decay_thr) begin
            env_d   = sus_tgt;
            state_d = SUSTAIN;
          end else begin
            env_d = env_q - decay_step;
          end
        end
        SUSTAIN: begin
          env_d = sus_tgt;
        end
        RELEASE: begin
          if (release_step == '0 || env_q <= release_step) begin
            env_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            env_d = env_q - release_step;
          end
        end
        default: begin
          env_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      env_q   <= '0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      done_q  <= done_d;
      gate_q  <= gate;
      armed_q <= armed_q | ~gate;
    end
  end

  assign envelope = env_q;
  assign state    = state_q;
  assign active   = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sample_tick = 1'b0;
  logic         gate = 1'b0;
  logic [W-1:0] attack_step = '0;
  logic [W-1:0] decay_step = '0;
  logic [W-1:0] sustain_level = '0;
  logic [W-1:0] release_step = '0;
  logic [W-1:0] envelope;
  logic [2:0]   state;
  logic         active;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  adsr_envelope #(.W(16), .FRAC(14), .FULL(16384)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .envelope     (envelope),
    .state        (state),
    .active       (active),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        g;
    logic        t;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] s;
    logic [15:0] r;
    logic [15:0] env;
    logic [2:0]  st;
    logic        dn;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [15:0] e_env,
                            input logic [2:0] e_st, input logic e_dn);
    check({tag, ".env"}, idx, 32'(envelope), 32'(e_env));
    check({tag, ".state"}, idx, 32'(state), 32'(e_st));
    check({tag, ".done"}, idx, 32'(done), 32'(e_dn));
    check({tag, ".active"}, idx, 32'(active), 32'(e_st != 3'd0));
  endtask

  // Called #1 after a posedge; applies inputs for one clk and samples #1 after the next edge.
  task automatic cycle(input logic g, input logic t);
    gate = g;
    sample_tick = t;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  initial begin
    // gate tick attack decay sustain release | env state done
    // Main ADSR pass, ticks spaced out by idle clks
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h0000, 3'd1, 0});
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h0000, 3'd1, 0});
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h0000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h1000, 3'd1, 0});
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h1000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h3000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h4000, 3'd2, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h3800, 3'd2, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h3000, 3'd2, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2800, 3'd2, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd3, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd3, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h1000, 3'd3, 0});
    vq.push_back('{0, 0, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h1000, 3'd4, 0});
    vq.push_back('{0, 1, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h0A00, 3'd4, 0});
    vq.push_back('{0, 1, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h0400, 3'd4, 0});
    vq.push_back('{0, 1, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h0000, 3'd0, 1});
    vq.push_back('{0, 0, 16'h1000, 16'h0800, 16'h1000, 16'h0600, 16'h0000, 3'd0, 0});
    // Fall during attack, re-rise during release (legato)
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h0000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h1000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd1, 0});
    vq.push_back('{0, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd4, 0});
    vq.push_back('{0, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h2000, 3'd4, 0});
    vq.push_back('{0, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0A00, 16'h1600, 3'd4, 0});
    vq.push_back('{0, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0A00, 16'h0C00, 3'd4, 0});
    vq.push_back('{1, 0, 16'h1000, 16'h0800, 16'h2000, 16'h0A00, 16'h0C00, 3'd1, 0});
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0A00, 16'h1C00, 3'd1, 0});
    // Zero steps and sustain clamp
    vq.push_back('{1, 1, 16'h0000, 16'h0800, 16'h2000, 16'h0A00, 16'h4000, 3'd2, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0800, 16'hFFFF, 16'h0A00, 16'h4000, 3'd3, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0800, 16'hFFFF, 16'h0A00, 16'h4000, 3'd3, 0});
    vq.push_back('{0, 0, 16'h0000, 16'h0800, 16'hFFFF, 16'h0A00, 16'h4000, 3'd4, 0});
    vq.push_back('{0, 1, 16'h0000, 16'h0800, 16'hFFFF, 16'h0000, 16'h0000, 3'd0, 1});
    vq.push_back('{0, 0, 16'h0000, 16'h0800, 16'hFFFF, 16'h0000, 16'h0000, 3'd0, 0});
    // Rise and tick together, zero decay step
    vq.push_back('{1, 1, 16'h1000, 16'h0800, 16'h2000, 16'h0600, 16'h1000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0800, 16'h2000, 16'h0600, 16'h4000, 3'd2, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0000, 16'h1000, 16'h0600, 16'h1000, 3'd3, 0});
    // Drive back into DECAY for the reset test
    vq.push_back('{0, 0, 16'h0000, 16'h0000, 16'h1000, 16'h0600, 16'h1000, 3'd4, 0});
    vq.push_back('{1, 0, 16'h0000, 16'h0000, 16'h1000, 16'h0600, 16'h1000, 3'd1, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0000, 16'h1000, 16'h0600, 16'h4000, 3'd2, 0});
    vq.push_back('{1, 1, 16'h0000, 16'h0100, 16'h0000, 16'h0600, 16'h3F00, 3'd2, 0});

    // Reset state
    #3;
    check_outs("reset", 0, 16'h0000, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    check_outs("post_reset", 0, 16'h0000, 3'd0, 1'b0);

    foreach (vq[i]) begin
      attack_step   = vq[i].a;
      decay_step    = vq[i].d;
      sustain_level = vq[i].s;
      release_step  = vq[i].r;
      cycle(vq[i].g, vq[i].t);
      check_outs("vec", i, vq[i].env, vq[i].st, vq[i].dn);
    end

    // Asynchronous reset between edges, mid-DECAY, with gate held high
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 0, 16'h0000, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("async_rst", 1, 16'h0000, 3'd0, 1'b0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Gate stayed high across reset: no new rise, stays idle with ticks
    for (int k = 0; k < 3; k++) begin
      attack_step = 16'h1000;
      cycle(1'b1, 1'b1);
      check_outs("held_gate", k, 16'h0000, 3'd0, 1'b0);
    end
    cycle(1'b0, 1'b0);
    check_outs("gate_low", 0, 16'h0000, 3'd0, 1'b0);
    cycle(1'b1, 1'b1);
    check_outs("new_rise", 0, 16'h1000, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
